// File: rtl/cvw.sv
// rtl/cvw.sv - shared core configuration type, arbiter state and AHB transfer encodings
package cvw;

    typedef struct packed {
        int PA_BITS;
        int AHBW;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{PA_BITS: 32, AHBW: 32};

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE = 2'b00;
    localparam arb_state_t ARB_OWN  = 2'b01;
    localparam arb_state_t ARB_LOCK = 2'b10;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // A manager is mid-transfer (and must not lose the bus) for anything but IDLE
    function automatic logic htrans_active(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ) || (t == HTRANS_BUSY);
    endfunction

endpackage

// File: rtl/flopenl.sv
// rtl/flopenl.sv - enabled flop with synchronous load of a reset value
module flopenl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] q
);

    // Load dominates the enable so reset lands even while the bus is stalled
    always_ff @(posedge clk) begin
        if (load) begin
            q <= val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/flopenr.sv
// rtl/flopenr.sv - enabled flop with synchronous active-low clear
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear dominates the enable so reset lands even while the bus is stalled
    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rrpick.sv
// rtl/rrpick.sv - combinational round-robin picker: requests plus start pointer to one-hot and index
module rrpick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Walk the requesters from ptr upward with wrap and keep the first one found
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == '0 && req[(int'(ptr) + k) % N]) begin
                grant[(int'(ptr) + k) % N] = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - round-robin AHB manager arbiter with locked transfers; AHBARB_PARK_EN keeps an idle owner parked
module ahb_rr_arbiter
    import cvw::*;
#(
    parameter cvw_t P  = CVW_DEFAULT,
    parameter int   NM = 2
) (
    input  logic                                 HCLK,
    input  logic                                 HRESETn,
    input  logic [NM-1:0][P.PA_BITS-1:0]         M_HADDR,
    input  logic [NM-1:0][P.AHBW-1:0]            M_HWDATA,
    input  logic [NM-1:0][P.AHBW/8-1:0]          M_HWSTRB,
    input  logic [NM-1:0][1:0]                   M_HTRANS,
    input  logic [NM-1:0][2:0]                   M_HSIZE,
    input  logic [NM-1:0][2:0]                   M_HBURST,
    input  logic [NM-1:0][3:0]                   M_HPROT,
    input  logic [NM-1:0]                        M_HWRITE,
    input  logic [NM-1:0]                        M_HMASTLOCK,
    output logic [NM-1:0]                        M_HREADY,
    output logic [NM-1:0]                        M_HRESP,
    output logic [P.AHBW-1:0]                    M_HRDATA,
    output logic [P.PA_BITS-1:0]                 HADDR,
    output logic [P.AHBW-1:0]                    HWDATA,
    output logic [P.AHBW/8-1:0]                  HWSTRB,
    output logic [1:0]                           HTRANS,
    output logic [2:0]                           HSIZE,
    output logic [2:0]                           HBURST,
    output logic [3:0]                           HPROT,
    output logic                                 HWRITE,
    output logic                                 HMASTLOCK,
    input  logic                                 HREADY,
    input  logic                                 HRESP,
    input  logic [P.AHBW-1:0]                    HRDATA,
    output logic [$clog2(NM)-1:0]                Owner,
    output logic                                 OwnerValid
);

    localparam int IW = $clog2(NM);

    arb_state_t    state;
    arb_state_t    state_d;
    logic [IW-1:0] owner_d;
    logic          valid_d;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_ptr_d;
    logic [IW-1:0] data_owner;
    logic [IW-1:0] owner_next;
    logic [IW-1:0] pick_ptr;
    logic [IW-1:0] pick_idx;
    logic [NM-1:0] pick_grant;
    logic [NM-1:0] req;
    logic          pick_any;
    logic          active;
    logic [1:0]    owner_trans;
    logic          owner_lock;

    // A manager asks for the bus whenever it presents NONSEQ or SEQ
    always_comb begin
        req = '0;
        for (int i = 0; i < NM; i++) begin
            req[i] = M_HTRANS[i][1];
        end
    end

    assign owner_trans = M_HTRANS[Owner];
    assign owner_lock  = M_HMASTLOCK[Owner];
    assign owner_next  = (Owner == IW'(NM - 1)) ? '0 : Owner + IW'(1);

    // From idle the search starts at the stored pointer; on hand-over it starts just past the owner
    assign pick_ptr = (state == ARB_IDLE) ? rr_ptr : owner_next;
    assign pick_any = |pick_grant;

    rrpick #(
        .N  (NM),
        .IW (IW)
    ) u_rrpick (
        .req   (req),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Ownership changes only when the owner shows IDLE outside a locked sequence
    always_comb begin
        state_d  = state;
        owner_d  = Owner;
        valid_d  = OwnerValid;
        rr_ptr_d = rr_ptr;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_OWN;
                    owner_d = pick_idx;
                    valid_d = 1'b1;
                end
            end
            ARB_OWN: begin
                if (!htrans_active(owner_trans)) begin
                    if (pick_any) begin
                        owner_d  = pick_idx;
                        rr_ptr_d = owner_next;
                    end else begin
`ifdef AHBARB_PARK_EN
                        state_d = ARB_OWN;
`else
                        state_d = ARB_IDLE;
                        valid_d = 1'b0;
`endif
                    end
                end else if (owner_lock) begin
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                if (!owner_lock && !htrans_active(owner_trans)) begin
                    state_d = ARB_OWN;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    flopenl #(.WIDTH(2)) u_state_reg (
        .clk  (HCLK),
        .load (~HRESETn),
        .en   (HREADY),
        .d    (state_d),
        .val  (ARB_IDLE),
        .q    (state)
    );

    flopenr #(.WIDTH(IW)) u_owner_reg (
        .clk    (HCLK),
        .resetn (HRESETn),
        .en     (HREADY),
        .d      (owner_d),
        .q      (Owner)
    );

    flopenr #(.WIDTH(1)) u_valid_reg (
        .clk    (HCLK),
        .resetn (HRESETn),
        .en     (HREADY),
        .d      (valid_d),
        .q      (OwnerValid)
    );

    flopenr #(.WIDTH(IW)) u_ptr_reg (
        .clk    (HCLK),
        .resetn (HRESETn),
        .en     (HREADY),
        .d      (rr_ptr_d),
        .q      (rr_ptr)
    );

    // The address phase accepted this cycle becomes next cycle's data phase
    flopenr #(.WIDTH(IW)) u_data_owner_reg (
        .clk    (HCLK),
        .resetn (HRESETn),
        .en     (HREADY),
        .d      (Owner),
        .q      (data_owner)
    );

    // Reset masks the forwarded transfer immediately so nothing in flight completes
    assign active    = HRESETn && (state != ARB_IDLE);
    assign HTRANS    = active ? owner_trans : HTRANS_IDLE;
    assign HMASTLOCK = active & owner_lock;
    assign HADDR     = M_HADDR[Owner];
    assign HSIZE     = M_HSIZE[Owner];
    assign HBURST    = M_HBURST[Owner];
    assign HPROT     = M_HPROT[Owner];
    assign HWRITE    = M_HWRITE[Owner];
    assign HWDATA    = M_HWDATA[data_owner];
    assign HWSTRB    = M_HWSTRB[data_owner];
    assign M_HRDATA  = HRDATA;

    // Only the address owner sees HREADY and only the data owner sees HRESP; everyone else is held
    always_comb begin
        M_HREADY = '0;
        M_HRESP  = '0;
        if (active) begin
            M_HREADY[Owner] = HREADY;
        end
        if (HRESETn) begin
            M_HRESP[data_owner] = HRESP;
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb/tb_ahb_rr_arbiter.sv - directed and randomized bench for ahb_rr_arbiter against a transaction-level model
module tb_ahb_rr_arbiter;

    localparam int NM = 4;
    localparam int PA = 32;
    localparam int DW = 32;
    localparam int IW = 2;
`ifdef AHBARB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NS   = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;

    logic clk = 1'b0;
    logic hresetn;
    logic [NM-1:0][PA-1:0]   m_haddr;
    logic [NM-1:0][DW-1:0]   m_hwdata;
    logic [NM-1:0][DW/8-1:0] m_hwstrb;
    logic [NM-1:0][1:0]      m_htrans;
    logic [NM-1:0][2:0]      m_hsize;
    logic [NM-1:0][2:0]      m_hburst;
    logic [NM-1:0][3:0]      m_hprot;
    logic [NM-1:0]           m_hwrite;
    logic [NM-1:0]           m_hmastlock;
    logic [NM-1:0]           m_hready;
    logic [NM-1:0]           m_hresp;
    logic [DW-1:0]           m_hrdata;
    logic [PA-1:0]           haddr;
    logic [DW-1:0]           hwdata;
    logic [DW/8-1:0]         hwstrb;
    logic [1:0]              htrans;
    logic [2:0]              hsize;
    logic [2:0]              hburst;
    logic [3:0]              hprot;
    logic                    hwrite;
    logic                    hmastlock;
    logic                    hready;
    logic                    hresp;
    logic [DW-1:0]           hrdata;
    logic [IW-1:0]           owner;
    logic                    owner_valid;

    int errors = 0;
    int checks = 0;

    int m_owner;
    int m_downer;
    int m_ptr;
    bit m_owned;
    bit m_locked;
    bit m_synced = 1'b0;

    always #5 clk = ~clk;

    ahb_rr_arbiter #(.NM(NM)) dut (
        .HCLK        (clk),
        .HRESETn     (hresetn),
        .M_HADDR     (m_haddr),
        .M_HWDATA    (m_hwdata),
        .M_HWSTRB    (m_hwstrb),
        .M_HTRANS    (m_htrans),
        .M_HSIZE     (m_hsize),
        .M_HBURST    (m_hburst),
        .M_HPROT     (m_hprot),
        .M_HWRITE    (m_hwrite),
        .M_HMASTLOCK (m_hmastlock),
        .M_HREADY    (m_hready),
        .M_HRESP     (m_hresp),
        .M_HRDATA    (m_hrdata),
        .HADDR       (haddr),
        .HWDATA      (hwdata),
        .HWSTRB      (hwstrb),
        .HTRANS      (htrans),
        .HSIZE       (hsize),
        .HBURST      (hburst),
        .HPROT       (hprot),
        .HWRITE      (hwrite),
        .HMASTLOCK   (hmastlock),
        .HREADY      (hready),
        .HRESP       (hresp),
        .HRDATA      (hrdata),
        .Owner       (owner),
        .OwnerValid  (owner_valid)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_from(input logic [NM-1:0] r, input int p);
        for (int k = 0; k < NM; k++) begin
            if (r[(p + k) % NM]) return (p + k) % NM;
        end
        return -1;
    endfunction

    // Reference: who owns the bus after this clock edge, from the arbitration rules
    task automatic model_advance();
        logic [NM-1:0] r;
        int w;
        if (!hresetn) begin
            m_owned = 0; m_locked = 0; m_owner = 0; m_downer = 0; m_ptr = 0; m_synced = 1'b1;
            return;
        end
        if (hready !== 1'b1) return;
        for (int i = 0; i < NM; i++) r[i] = m_htrans[i][1];
        m_downer = m_owner;
        if (!m_owned) begin
            w = first_from(r, m_ptr);
            if (w >= 0) begin m_owned = 1; m_owner = w; end
        end else if (m_locked) begin
            if (!m_hmastlock[m_owner] && m_htrans[m_owner] == T_IDLE) m_locked = 0;
        end else if (m_htrans[m_owner] == T_IDLE) begin
            w = first_from(r, (m_owner + 1) % NM);
            if (w >= 0) begin
                m_ptr   = (m_owner + 1) % NM;
                m_owner = w;
            end else if (!PARK) begin
                m_owned = 0;
            end
        end else if (m_hmastlock[m_owner]) begin
            m_locked = 1;
        end
    endtask

    task automatic model_check();
        logic act;
        logic [NM-1:0] er;
        logic [NM-1:0] ep;
        act = hresetn && m_owned;
        er = '0;
        ep = '0;
        if (act) er[m_owner] = hready;
        if (hresetn) ep[m_downer] = hresp;
        check("htrans", 64'(htrans), 64'(act ? m_htrans[m_owner] : T_IDLE));
        check("hmastlock", 64'(hmastlock), 64'(act ? m_hmastlock[m_owner] : 1'b0));
        check("m_hready", 64'(m_hready), 64'(er));
        check("m_hresp", 64'(m_hresp), 64'(ep));
        check("owner", 64'(owner), 64'(m_owner));
        check("owner_valid", 64'(owner_valid), 64'(m_owned));
        check("hwdata", 64'(hwdata), 64'(m_hwdata[m_downer]));
        check("hwstrb", 64'(hwstrb), 64'(m_hwstrb[m_downer]));
        check("m_hrdata", 64'(m_hrdata), 64'(hrdata));
        if (act) begin
            check("haddr", 64'(haddr), 64'(m_haddr[m_owner]));
            check("hwrite", 64'(hwrite), 64'(m_hwrite[m_owner]));
            check("hsize", 64'(hsize), 64'(m_hsize[m_owner]));
            check("hburst", 64'(hburst), 64'(m_hburst[m_owner]));
            check("hprot", 64'(hprot), 64'(m_hprot[m_owner]));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (m_synced) model_check();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [1:0] t, input logic lk, input logic wr, input logic [31:0] a);
        m_htrans[i]    = t;
        m_hmastlock[i] = lk;
        m_hwrite[i]    = wr;
        m_haddr[i]     = a;
    endtask

    task automatic idle_all();
        m_htrans = '0;
        m_hmastlock = '0;
        hready = 1'b1;
        hresp = 1'b0;
        hrdata = $urandom;
        for (int i = 0; i < NM; i++) begin
            m_haddr[i]  = $urandom;
            m_hwdata[i] = $urandom;
            m_hwstrb[i] = 4'($urandom);
            m_hsize[i]  = 3'($urandom);
            m_hburst[i] = 3'($urandom);
            m_hprot[i]  = 4'($urandom);
            m_hwrite[i] = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        idle_all();
        hresp = 1'b1;
        tick();
        tick();
        check("rst_htrans", 64'(htrans), 64'(T_IDLE));
        check("rst_hmastlock", 64'(hmastlock), 64'd0);
        check("rst_m_hready", 64'(m_hready), 64'd0);
        check("rst_m_hresp", 64'(m_hresp), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_owner_valid", 64'(owner_valid), 64'd0);
        hresp = 1'b0;
        hresetn = 1'b1;
    endtask

    initial begin
        int r;

        // single manager: grant latency of one cycle
        do_reset();
        drive(0, T_NS, 1'b0, 1'b0, 32'h8000_0000);
        #1;
        check("s1_c1_htrans", 64'(htrans), 64'(T_IDLE));
        check("s1_c1_m_hready", 64'(m_hready), 64'd0);
        tick();
        check("s1_c2_htrans", 64'(htrans), 64'(T_NS));
        check("s1_c2_haddr", 64'(haddr), 64'h8000_0000);
        check("s1_c2_m_hready", 64'(m_hready), 64'b0001);
        check("s1_c2_owner", 64'(owner), 64'd0);
        check("s1_c2_owner_valid", 64'(owner_valid), 64'd1);
        drive(0, T_IDLE, 1'b0, 1'b0, 32'h8000_0000);
        tick();
        tick();

        // simultaneous requests: M0 first, M1 held until M0 idles
        do_reset();
        drive(0, T_NS, 1'b0, 1'b1, 32'h100);
        drive(1, T_NS, 1'b0, 1'b0, 32'h200);
        tick();
        check("s2_owner_m0", 64'(owner), 64'd0);
        check("s2_haddr_m0", 64'(haddr), 64'h100);
        check("s2_m_hready_m0", 64'(m_hready), 64'b0001);
        tick();
        drive(0, T_IDLE, 1'b0, 1'b0, 32'h100);
        #1;
        check("s2_m1_waiting", 64'(m_hready[1]), 64'd0);
        tick();
        check("s2_owner_m1", 64'(owner), 64'd1);
        check("s2_haddr_m1", 64'(haddr), 64'h200);
        check("s2_m_hready_m1", 64'(m_hready), 64'b0010);
        drive(1, T_IDLE, 1'b0, 1'b0, 32'h200);
        tick();

        // INCR4 burst with a wait state is never split
        do_reset();
        drive(0, T_NS, 1'b0, 1'b1, 32'h400);
        drive(1, T_NS, 1'b0, 1'b0, 32'h500);
        tick();
        for (int b = 0; b < 4; b++) begin
            drive(0, (b == 0) ? T_NS : T_SEQ, 1'b0, 1'b1, 32'h400 + 32'(4 * b));
            if (b == 2) begin
                hready = 1'b0;
                tick();
                hready = 1'b1;
            end
            #1;
            check("s3_burst_owner", 64'(owner), 64'd0);
            check("s3_burst_m1_held", 64'(m_hready[1]), 64'd0);
            tick();
        end
        drive(0, T_IDLE, 1'b0, 1'b0, 32'h410);
        #1;
        check("s3_owner_at_idle", 64'(owner), 64'd0);
        tick();
        check("s3_owner_m1", 64'(owner), 64'd1);
        check("s3_haddr_m1", 64'(haddr), 64'h500);
        drive(1, T_IDLE, 1'b0, 1'b0, 32'h500);
        tick();

        // locked read-modify-write keeps M1 out through the gap
        do_reset();
        drive(0, T_NS, 1'b1, 1'b0, 32'h600);
        drive(1, T_NS, 1'b0, 1'b0, 32'h700);
        tick();
        check("s4_hmastlock", 64'(hmastlock), 64'd1);
        tick();
        drive(0, T_IDLE, 1'b1, 1'b0, 32'h600);
        #1;
        check("s4_gap_m1_held", 64'(m_hready[1]), 64'd0);
        tick();
        check("s4_gap_owner", 64'(owner), 64'd0);
        drive(0, T_NS, 1'b1, 1'b1, 32'h600);
        tick();
        check("s4_write_owner", 64'(owner), 64'd0);
        drive(0, T_IDLE, 1'b0, 1'b0, 32'h600);
        tick();
        tick();
        check("s4_owner_m1", 64'(owner), 64'd1);
        check("s4_m_hready_m1", 64'(m_hready), 64'b0010);
        drive(1, T_IDLE, 1'b0, 1'b0, 32'h700);
        tick();

        // two-cycle error response routed only to the data-phase owner
        do_reset();
        drive(1, T_NS, 1'b0, 1'b1, 32'h900);
        tick();
        check("s5_owner_m1", 64'(owner), 64'd1);
        m_hwdata[1] = 32'hDEAD_BEEF;
        tick();
        drive(1, T_IDLE, 1'b0, 1'b0, 32'h900);
        drive(0, T_NS, 1'b0, 1'b0, 32'hA00);
        hready = 1'b0;
        hresp = 1'b1;
        #1;
        check("s5_err1_m_hresp", 64'(m_hresp), 64'b0010);
        check("s5_err1_hwdata", 64'(hwdata), 64'hDEAD_BEEF);
        tick();
        check("s5_err1_owner_held", 64'(owner), 64'd1);
        hready = 1'b1;
        #1;
        check("s5_err2_m_hresp", 64'(m_hresp), 64'b0010);
        tick();
        hresp = 1'b0;
        #1;
        check("s5_after_owner_m0", 64'(owner), 64'd0);
        drive(0, T_IDLE, 1'b0, 1'b0, 32'hA00);
        tick();

        // re-request after an idle cycle: parked owner goes straight out
        do_reset();
        drive(0, T_NS, 1'b0, 1'b0, 32'hB00);
        tick();
        tick();
        drive(0, T_IDLE, 1'b0, 1'b0, 32'hB00);
        tick();
        drive(0, T_NS, 1'b0, 1'b0, 32'hB04);
        #1;
        check("s6_rereq_same_cycle", 64'(htrans), 64'(PARK ? T_NS : T_IDLE));
        tick();
        check("s6_rereq_next_cycle", 64'(htrans), 64'(T_NS));
        drive(0, T_IDLE, 1'b0, 1'b0, 32'hB04);
        tick();

        // randomized traffic, stalls, errors and occasional mid-flight reset
        for (int n = 0; n < 3000; n++) begin
            hresetn = ($urandom_range(0, 199) != 0);
            hready  = ($urandom_range(0, 3) != 0);
            hresp   = ($urandom_range(0, 7) == 0);
            hrdata  = $urandom;
            for (int i = 0; i < NM; i++) begin
                r = $urandom_range(0, 9);
                m_htrans[i]    = (r < 4) ? T_IDLE : (r < 6) ? T_NS : (r < 8) ? T_SEQ : T_BUSY;
                m_hmastlock[i] = ($urandom_range(0, 5) == 0);
                m_haddr[i]     = $urandom;
                m_hwdata[i]    = $urandom;
                m_hwstrb[i]    = 4'($urandom);
                m_hsize[i]     = 3'($urandom);
                m_hburst[i]    = 3'($urandom);
                m_hprot[i]     = 4'($urandom);
                m_hwrite[i]    = 1'($urandom);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_rr_arbiter.md
AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 Parameters SHALL be: P, cvw_t, core configuration (PA_BITS, AHBW); NM, 2, number of managers (2..4).
REQ-002 Ports SHALL be: HCLK in 1, bus clock; HRESETn in 1, reset.
REQ-003 Reset SHALL be synchronous and active-low: one clock HCLK; reset HRESETn sampled on the rising HCLK edge.
REQ-004 M_HADDR in [NM][PA_BITS], M_HWDATA in [NM][AHBW], M_HWSTRB in [NM][AHBW/8]: per-manager address and write data.
REQ-005 M_HTRANS in [NM][2], M_HSIZE/M_HBURST in [NM][3], M_HPROT in [NM][4], M_HWRITE/M_HMASTLOCK in [NM]: per-manager control.
REQ-006 M_HREADY out [NM], M_HRESP out [NM], M_HRDATA out [AHBW]: per-manager response.
REQ-007 HADDR, HWDATA, HWSTRB, HTRANS, HSIZE, HBURST, HPROT, HWRITE, HMASTLOCK out: the same widths toward the uncore.
REQ-008 HREADY in 1, HRESP in 1, HRDATA in [AHBW]: the uncore response.
REQ-009 Owner out [$clog2(NM)] and OwnerValid out 1: the current address-phase owner.

Function
REQ-010 The FSM SHALL have the states ARB_IDLE (no owner), ARB_OWN and ARB_LOCK.
REQ-011 State, Owner, DataOwner and the round-robin pointer SHALL update only on cycles with HREADY=1.
REQ-012 A manager SHALL request when M_HTRANS[i][1]=1.
REQ-013 ARB_IDLE: forward HTRANS=IDLE.
  - If any request is present, grant the first requester at or after RrPtr and enter ARB_OWN. The grant is registered, so there is 1 cycle of grant latency.
REQ-014 ARB_OWN: forward the Owner's address-phase signals.
  - M_HREADY[Owner]=HREADY; every other M_HREADY=0, so non-owners hold their address.
REQ-015 ARB_OWN with owner HTRANS=IDLE and HREADY=1 SHALL re-arbitrate.
  - Another request present: set RrPtr=Owner+1 mod NM, grant the next requester round-robin, stay in ARB_OWN.
  - No other request: behave per REQ-024.
REQ-016 The owner SHALL never be switched while its HTRANS is NONSEQ, SEQ or BUSY, so bursts are never split.
REQ-017 Owner HMASTLOCK=1 with HTRANS≠IDLE SHALL enter ARB_LOCK.
  - ARB_LOCK ignores the IDLE hand-over condition.
  - ARB_LOCK returns to ARB_OWN when HMASTLOCK=0 and HTRANS=IDLE with HREADY=1.
REQ-018 DataOwner SHALL load Owner whenever HREADY=1.
  - HWDATA/HWSTRB = M_HWDATA/M_HWSTRB[DataOwner].
  - M_HRESP[DataOwner]=HRESP; all other M_HRESP=0.
REQ-019 M_HRDATA SHALL equal HRDATA, broadcast to all managers.
REQ-020 Simultaneous requests SHALL be resolved by RrPtr priority; the ascending index after RrPtr wins.
REQ-021 HRESP=1 in the first error cycle (HREADY=0) SHALL hold the owner; the error is passed only to DataOwner.
REQ-022 A request appearing while its manager is non-owner SHALL see M_HREADY=0 until it is granted and the grant takes effect.

Reset
REQ-023 On HRESETn=0, the FSM SHALL reset as follows:
  - state=ARB_IDLE, Owner=0, OwnerValid=0, DataOwner=0, RrPtr=0.
  - Forwarded HTRANS=IDLE and HMASTLOCK=0.
  - All M_HREADY=0 and all M_HRESP=0.
  - Reset SHALL abort any in-flight transfer without completing it.

Configuration
REQ-024 Parking SHALL be controlled by the macro AHBARB_PARK_EN.
  - Defined: with no other request, the owner stays parked in ARB_OWN, so its next NONSEQ is forwarded with 0-cycle latency.
  - Undefined: with no other request, go to ARB_IDLE and set OwnerValid=0; every new request costs 1 grant cycle.

Structure
REQ-025 arb_state_t (ARB_IDLE, ARB_OWN, ARB_LOCK) and the HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11) SHALL reside in cvw package.
REQ-026 The sub-module rrpick SHALL be the combinational round-robin picker: requests + pointer -> one-hot/index.
  - The state, pointer and data-phase flops SHALL use the flopenr and flopenl library cells.

Verification
REQ-027 The bench SHALL cover the following scenarios:
  - Reset then M0 NONSEQ to 0x8000_0000, no park -> HTRANS=NONSEQ forwarded on cycle 2, M_HREADY[0]=1, Owner=0.
  - M0 and M1 request together, RrPtr=0 -> M0 served first; when M0 goes IDLE, M1 is granted the next cycle and M_HREADY[1] stays 0 until then.
  - M0 INCR4 burst with an M1 request pending -> 4 beats uninterrupted, then M1 granted.
  - M0 HMASTLOCK read-modify-write, M1 pending -> M1 is blocked through the IDLE between the locked transfers and granted after the lock drops.
  - Error response on a M1 write -> M_HRESP[1]=1 for 2 cycles, M_HRESP[0]=0.
  - With AHBARB_PARK_EN: M0 re-requests after IDLE -> forwarded the same cycle; without it, 1 cycle later.
